// File: rtl/vpu_pkg.sv
// Shared VPU definitions: opcodes, IR field positions, sequencer states.
package vpu_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 17;
  localparam int IMM_BIT = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 0;

  localparam logic [4:0] OP_MOVSGPR = 5'b00000;
  localparam logic [4:0] OP_MOV     = 5'b00001;
  localparam logic [4:0] OP_ADD     = 5'b00010;
  localparam logic [4:0] OP_SUB     = 5'b00011;
  localparam logic [4:0] OP_MUL     = 5'b00100;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    DONE,
    ERR
  } seq_state_t;

  function automatic logic op_exec(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_MOVSGPR, OP_MOV, OP_ADD,
      OP_SUB, OP_MUL: ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/vpu_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
module vpu_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/vpu_seq_ctrl.sv
// VPU program sequencer: fetch, decode, issue over valid/ready.
// Define VPU_SEQ_PERF_EN to add cycle_cnt / stall_cnt outputs.
module vpu_seq_ctrl
  import vpu_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IMEM_AW-1:0] start_pc,
  input  logic               abort,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               exe_valid,
  output logic [31:0]        exe_ir,
  input  logic               exe_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IMEM_AW-1:0] pc,
  output logic [CNT_W-1:0]   instr_cnt
`ifdef VPU_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  seq_state_t state;
  seq_state_t state_nxt;
  logic [31:0] ir;
  logic [4:0]  op_rd;
  logic        idle_like;
  logic        start_ok;
  logic        fire;

  assign op_rd     = imem_rdata[OP_MSB:OP_LSB];
  assign idle_like = (state == IDLE) || (state == DONE)
                  || (state == ERR);
  assign start_ok  = start && !abort && idle_like;
  assign fire      = (state == ISSUE) && exe_ready && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE, ERR:
          if (start) state_nxt = FETCH;
        FETCH:
          state_nxt = DECODE;
        DECODE:
          if (op_rd == OP_HALT)
            state_nxt = DONE;
          else if (!op_exec(op_rd))
            state_nxt = ERR;
          else
            state_nxt = ISSUE;
        ISSUE:
          if (exe_ready) state_nxt = FETCH;
        default:
          state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_en   = 1'b0;
    exe_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      FETCH: begin
        imem_en = 1'b1;
        busy    = 1'b1;
      end
      DECODE: busy = 1'b1;
      ISSUE: begin
        exe_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;
  assign exe_ir    = exe_valid ? ir : 32'h0;

  // IR keeps HALT/illegal words too, so the host can inspect them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (start_ok)
        pc <= start_pc;
      else if (fire)
        pc <= pc + 1'b1;
      if ((state == DECODE) && !abort)
        ir <= imem_rdata;
    end
  end

  vpu_sat_cnt #(.W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (fire),
    .q   (instr_cnt)
  );

`ifdef VPU_SEQ_PERF_EN
  vpu_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (busy),
    .q   (cycle_cnt)
  );

  vpu_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc ((state == ISSUE) && !exe_ready),
    .q   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_vpu_seq_ctrl.sv
// Scoreboard bench for vpu_seq_ctrl with a synchronous-read imem model.
module tb_vpu_seq_ctrl;

  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          abort = 1'b0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic          exe_valid;
  logic [31:0]   exe_ir;
  logic          exe_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] pc;
  logic [CW-1:0] instr_cnt;
`ifdef VPU_SEQ_PERF_EN
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:255];

  vpu_seq_ctrl #(.IMEM_AW(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_pc   (start_pc),
    .abort      (abort),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .exe_valid  (exe_valid),
    .exe_ir     (exe_ir),
    .exe_ready  (exe_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pc         (pc),
    .instr_cnt  (instr_cnt)
`ifdef VPU_SEQ_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        pa = 1'b0;
  logic        prst = 1'b1;
  logic [31:0] pir = 32'h0;

  // Monitor: handshakes pop the scoreboard; stalls must hold valid/ir.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (exe_valid && exe_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_handshake actual=%h required=none",
                   exe_ir);
        end else begin
          e = exp_q.pop_front();
          chk("handshake_ir", exe_ir, e);
        end
      end
      if (pv && !pr && !pa && !prst) begin
        chk("stall_valid", {31'h0, exe_valid}, 32'h1);
        chk("stall_ir", exe_ir, pir);
      end
    end
    pv   = exe_valid;
    pr   = exe_ready;
    pa   = abort;
    prst = rst;
    pir  = exe_ir;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns edges until done/err (bounded).
  task automatic run(input logic [AW-1:0] spc, output int n);
    start    = 1'b1;
    start_pc = spc;
    step();
    start = 1'b0;
    n = 1;
    while (!done && !err && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=%0d required=<60", n);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_err"}, {31'h0, err}, 32'h0);
    chk({tag, "_valid"}, {31'h0, exe_valid}, 32'h0);
    chk({tag, "_imem_en"}, {31'h0, imem_en}, 32'h0);
    chk({tag, "_exe_ir"}, exe_ir, 32'h0);
    chk({tag, "_pc"}, {24'h0, pc}, 32'h0);
    chk({tag, "_addr"}, {24'h0, imem_addr}, 32'h0);
    chk({tag, "_icnt"}, {16'h0, instr_cnt}, 32'h0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 32'hF800_0000;
    mem[8'h10] = 32'h0841_0005;
    mem[8'h11] = 32'h1083_0003;
    mem[8'h12] = 32'hF800_0000;
    mem[8'h20] = 32'h2045_0800;
    mem[8'h03] = 32'h4800_0000;
    mem[8'h00] = 32'hF800_0000;
    mem[8'hFF] = 32'h0841_0005;
    mem[8'h30] = 32'h1083_0003;

    step();
    chk_reset("rst");
    rst = 1'b0;
    step();

    // Basic program: two retires then HALT, 9 edges to done.
    exp_q.push_back(32'h0841_0005);
    exp_q.push_back(32'h1083_0003);
    run(8'h10, n);
    chk("prog_cycles", n, 9);
    chk("prog_done", {31'h0, done}, 32'h1);
    chk("prog_pc", {24'h0, pc}, 32'h12);
    chk("prog_icnt", {16'h0, instr_cnt}, 32'h2);
    chk("prog_q_empty", exp_q.size(), 0);

    // mul held by exe_ready low for 4 ISSUE cycles.
    exe_ready = 1'b0;
    exp_q.push_back(32'h2045_0800);
    start    = 1'b1;
    start_pc = 8'h20;
    step();
    start = 1'b0;
    n = 0;
    while (!exe_valid && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("mul_valid", {31'h0, exe_valid}, 32'h1);
      chk("mul_ir", exe_ir, 32'h2045_0800);
      step();
    end
    chk("mul_valid5", {31'h0, exe_valid}, 32'h1);
    exe_ready = 1'b1;
    step();
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("mul_done", {31'h0, done}, 32'h1);
    chk("mul_icnt", {16'h0, instr_cnt}, 32'h1);
    chk("mul_pc", {24'h0, pc}, 32'h21);
`ifdef VPU_SEQ_PERF_EN
    chk("mul_stall", {16'h0, stall_cnt}, 32'h4);
    chk("mul_cycles", {16'h0, cycle_cnt}, 32'h9);
`endif

    // Illegal opcode at 0x03.
    run(8'h03, n);
    chk("ill_err", {31'h0, err}, 32'h1);
    chk("ill_done", {31'h0, done}, 32'h0);
    chk("ill_pc", {24'h0, pc}, 32'h03);
    chk("ill_icnt", {16'h0, instr_cnt}, 32'h0);
    run(8'h00, n);
    chk("ill_clr_err", {31'h0, err}, 32'h0);
    chk("ill_clr_done", {31'h0, done}, 32'h1);

    // PC wrap 0xFF -> 0x00.
    exp_q.push_back(32'h0841_0005);
    run(8'hFF, n);
    chk("wrap_done", {31'h0, done}, 32'h1);
    chk("wrap_pc", {24'h0, pc}, 32'h00);
    chk("wrap_icnt", {16'h0, instr_cnt}, 32'h1);

    // Abort coinciding with exe_ready in ISSUE.
    start    = 1'b1;
    start_pc = 8'h30;
    step();
    start = 1'b0;
    n = 0;
    while (!exe_valid && n < 10) begin
      step();
      n++;
    end
    chk("abort_saw_valid", {31'h0, exe_valid}, 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", {31'h0, exe_valid}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_icnt", {16'h0, instr_cnt}, 32'h0);
    chk("abort_pc", {24'h0, pc}, 32'h30);
    step();
    chk("abort_idle", {31'h0, busy | done | err}, 32'h0);

    // Reset mid-FETCH.
    start    = 1'b1;
    start_pc = 8'h10;
    step();
    start = 1'b0;
    chk("pre_rst_fetch", {31'h0, imem_en}, 32'h1);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    step();
    rst = 1'b0;
    step();

    // Start while busy is ignored.
    exp_q.push_back(32'h0841_0005);
    exp_q.push_back(32'h1083_0003);
    start    = 1'b1;
    start_pc = 8'h10;
    step();
    start_pc = 8'h40;
    step();
    start = 1'b0;
    chk("busy_start_pc", {24'h0, pc}, 32'h10);
    n = 0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    chk("busy_done", {31'h0, done}, 32'h1);
    chk("busy_pc", {24'h0, pc}, 32'h12);
    chk("busy_icnt", {16'h0, instr_cnt}, 32'h2);
    step();
    chk("final_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
